clip_rr_arb: RTL

Round-robin arbiter that shares one registered saturating clipper among NUM_CH streaming requesters. Each requester presents wide samples with a valid/ready handshake. The winner's sample is clipped from BITS_IN to BITS_OUT, keeping the bottom bits with signed saturation. The result is emitted on a single tagged output stream. It sits between per-channel DSP stages (e.g. CIC/halfband outputs) and a shared narrow output path. Per-channel sticky clip flags are provided for status readback.

---
 rtl/clip_rr_arb.sv | 67 ++++++
 1 files changed

// File: rtl/clip_rr_arb.sv
// clip_rr_arb: round-robin arbiter sharing one registered saturating clipper; in_* per-channel AXIS inputs, out_* tagged clipped stream, clip_sticky per-channel status
module clip_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int BITS_IN = 24,
  parameter int BITS_OUT = 16,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*BITS_IN-1:0] in_tdata,
  input  logic [NUM_CH-1:0]         in_tvalid,
  output logic [NUM_CH-1:0]         in_tready,
  output logic [BITS_OUT-1:0]       out_tdata,
  output logic [CW-1:0]             out_chan,
  output logic                      out_clip,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  input  logic [NUM_CH-1:0]         clear_sticky,
  output logic [NUM_CH-1:0]         clip_sticky
);
  logic [CW-1:0] r_last, r_chan, w_gnt;
  logic [BITS_OUT-1:0] r_data, w_res;
  logic [NUM_CH-1:0] r_sticky;
  logic [BITS_IN-1:0] w_x;
  logic [BITS_IN-BITS_OUT:0] w_top;
  logic r_vld, r_clip, w_any, w_ld, w_xfer, w_clip;
  always_comb begin
    w_gnt = r_last;
    w_any = 1'b0;
    for (int k = NUM_CH; k >= 1; k--)
      if (in_tvalid[(int'(r_last) + k) % NUM_CH]) begin
        w_gnt = CW'((int'(r_last) + k) % NUM_CH);
        w_any = 1'b1;
      end
  end
  assign w_ld = ~r_vld | out_tready;
  assign w_xfer = w_any & w_ld & ~reset;
  assign in_tready = w_xfer ? {{(NUM_CH-1){1'b0}}, 1'b1} << w_gnt : '0;
  assign w_x = in_tdata[int'(w_gnt)*BITS_IN +: BITS_IN];
  assign w_top = w_x[BITS_IN-1:BITS_OUT-1];
  assign w_clip = ~(&w_top | ~|w_top);
  assign w_res = w_clip ? {w_x[BITS_IN-1], {(BITS_OUT-1){~w_x[BITS_IN-1]}}} : w_x[BITS_OUT-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_data <= '0;
      r_chan <= '0;
      r_clip <= 1'b0;
      r_sticky <= '0;
      r_last <= CW'(NUM_CH-1);
    end else begin
      if (w_xfer) begin
        r_data <= w_res;
        r_chan <= w_gnt;
        r_clip <= w_clip;
        r_vld <= 1'b1;
        r_last <= w_gnt;
      end else if (out_tready) r_vld <= 1'b0;
      r_sticky <= (r_sticky & ~clear_sticky) | (w_clip ? in_tready : '0);
    end
  end
  assign out_tdata = r_data;
  assign out_chan = r_chan;
  assign out_clip = r_clip;
  assign out_tvalid = r_vld;
  assign clip_sticky = r_sticky;
endmodule
